// File: rtl/bram_heap_insert_stage.sv
// One level of a BRAM-backed pipelined max-heap. A token {value, leaf path} arrives here.
// The larger of the token value and the stored node stays at this level. The smaller one moves down.
module bram_heap_insert_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LEVEL      = 1,
  parameter int ADDR_WIDTH = (LEVEL > 0) ? LEVEL : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DEPTH-2:0]      i_path,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DEPTH-2:0]      o_path,
  output logic                  o_ram_read,
  output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_ram_write,
  output logic [ADDR_WIDTH-1:0] o_ram_wrt_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_overflow,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CMP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam bit LAST  = (LEVEL == DEPTH - 1);
  localparam int SHIFT = DEPTH - 1 - LEVEL;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic [DEPTH-2:0]      path_q, path_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-2:0]      opath_q, opath_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  ovf_q, ovf_d;

  logic [DEPTH-2:0]      path_shift;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  fwd;
  logic [DATA_WIDTH-1:0] fwd_val;

  // The top LEVEL bits of the leaf path pick the node on this level.
  assign path_shift = i_path >> SHIFT;
  assign in_idx     = path_shift[ADDR_WIDTH-1:0];

  // Both sides use valid/ready. A token moves on the rising edge where valid and ready are both high.
  // The sender holds valid and its payload steady until that edge.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    path_d    = path_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    data_d    = data_q;
    opath_d   = opath_q;
    rd_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;
    fwd       = 1'b0;
    fwd_val   = '0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (i_valid && ready_q && (i_data != '0)) begin
          v_d       = i_data;
          path_d    = i_path;
          idx_d     = in_idx;
          rd_d      = 1'b1;
          rd_addr_d = in_idx;
          ready_d   = 1'b0;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        state_d = S_OUT;
        if (i_ram_data == '0) begin
          wr_d = 1'b1;
        end else if (v_q > i_ram_data) begin
          wr_d    = 1'b1;
          fwd     = 1'b1;
          fwd_val = i_ram_data;
        end else begin
          fwd     = 1'b1;
          fwd_val = v_q;
        end
        if (wr_d) begin
          wr_addr_d = idx_q;
          wr_data_d = v_q;
        end
        // The leaf level has nowhere to send a displaced value, so it only records the loss.
        if (fwd) begin
          if (LAST) begin
            ovf_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = fwd_val;
            opath_d = path_q;
          end
        end
      end
      S_OUT: begin
        if (!valid_q || i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      v_q       <= '0;
      path_q    <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      opath_q   <= '0;
      rd_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      path_q    <= path_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      opath_q   <= opath_d;
      rd_q      <= rd_d;
      rd_addr_q <= rd_addr_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_ready         = ready_q;
  assign o_valid         = valid_q;
  assign o_data          = data_q;
  assign o_path          = opath_q;
  assign o_ram_read      = rd_q;
  assign o_ram_read_addr = rd_addr_q;
  assign o_ram_write     = wr_q;
  assign o_ram_wrt_addr  = wr_addr_q;
  assign o_ram_data      = wr_data_q;
  assign o_overflow      = ovf_q;
  assign o_dbg_state     = state_q;

endmodule

// File: doc/bram_heap_insert_stage.md
Name: bram_heap_insert_stage

Overview:
- One pipeline stage of the BRAM-backed pipelined max-heap. Each stage owns one tree level and drives that level's BRAM read and write ports. The stage sits directly upstream of the BRAM.
- Performs top-down insertion. It accepts a token {value, leaf path}, reads the node on the path at its level, keeps the larger of the two values, and forwards the smaller one to the next stage.
- Stages are chained from LEVEL=0 (root) to LEVEL=DEPTH-1 (leaves).

Parameters:
- DATA_WIDTH, 32: key width. Value 0 is reserved and means "empty slot".
- DEPTH, 4: total tree levels. DEPTH must be ≥2.
- LEVEL, 1: level owned by this stage, in the range 0..DEPTH-1. Level L holds 2^L nodes.
- ADDR_WIDTH, (LEVEL>0 ? LEVEL : 1): BRAM address width. The integrator zero-extends this to the BRAM address port.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- i_valid  in  1  upstream token valid.
- o_ready  out  1  stage can accept a token.
- i_data  in  DATA_WIDTH  value to insert.
- i_path  in  DEPTH-1  target leaf index; it selects the node at every level.
- o_valid  out  1  downstream token valid.
- i_ready  in  1  downstream accepts the token.
- o_data  out  DATA_WIDTH  value forwarded downstream.
- o_path  out  DEPTH-1  copy of the accepted i_path.
- o_ram_read  out  1  BRAM read enable.
- o_ram_read_addr  out  ADDR_WIDTH  BRAM read address.
- i_ram_data  in  DATA_WIDTH  BRAM read data, valid one cycle after o_ram_read.
- o_ram_write  out  1  BRAM write enable.
- o_ram_wrt_addr  out  ADDR_WIDTH  BRAM write address.
- o_ram_data  out  DATA_WIDTH  BRAM write data.
- o_overflow  out  1  sticky flag: the last level was asked to forward a value.

Behaviour:
- All outputs are registered. On RST, every output is 0 (including o_ready) and the FSM goes to IDLE. o_ready rises the cycle after RST deasserts.
- Node index: idx = i_path >> (DEPTH-1-LEVEL), truncated to ADDR_WIDTH. For LEVEL=0, idx=0.
- FSM states are IDLE, RD, CMP, OUT.
- IDLE: o_ready=1. On i_valid&&o_ready, latch v=i_data, path=i_path and idx, then go to RD.
  - If i_data==0, consume the token and stay in IDLE with no BRAM access.
- RD: o_ram_read=1 and o_ram_read_addr=idx for exactly one cycle, then go to CMP.
- CMP: c=i_ram_data. Register the decision and go to OUT.
  - c==0: write v at idx; no forward.
  - v>c (unsigned): write v at idx; forward c.
  - v<=c: no write; forward v. Equal values are not swapped.
- OUT: o_ram_write is a one-cycle pulse in the first OUT cycle only, if a write was decided. o_valid=1 if a forward was decided. Hold o_data and o_path stable until i_valid-style handshake o_valid&&i_ready, then go to IDLE. With no forward, go to IDLE after one cycle.
- Last level (LEVEL==DEPTH-1): o_valid is never asserted. A decided forward instead sets o_overflow, which stays 1 until RST; the forwarded value is dropped.
- Throughput is one token per ≥3 cycles. A write always commits before the next read issues, so there is no read-after-write hazard and no bypass is needed.
- RST in any state discards the in-flight token. A write not yet pulsed is never issued. The stage never resets BRAM contents.
- Read and write are never asserted in the same cycle.

Test Plan (DEPTH=4, LEVEL=1 unless noted):
- Empty slot: ram[1]=0; accept v=5, path=3'b110. Expect a read of addr 1 the cycle after accept, then a write of addr 1 with data 5 two cycles later, o_valid stays 0, and o_ready=1 three cycles after accept.
- Swap: ram[0]=7; accept v=9, path=3'b010. Expect a write of 9 at addr 0, o_valid=1 with o_data=7 and o_path=3'b010.
- Pass-through, including ties: ram[0]=7; accept v=4, then later v=7. Expect no o_ram_write; forwarded o_data=4, then 7.
- Backpressure: during the swap case, hold i_ready=0 for 5 cycles. Expect o_valid, o_data and o_path stable, o_ready=0, and exactly one write pulse. Raise i_ready; expect the handshake and a return to IDLE.
- Overflow (LEVEL=3): ram[6]=8; accept v=3, path=3'b110. Expect no write, no o_valid, and o_overflow=1 held until RST. Then accept i_data=0 and expect it consumed with no BRAM activity.
- Reset mid-operation: assert RST in the CMP cycle of the swap case. Expect no o_ram_write ever, all outputs 0, ram[0] still 7, and o_ready=1 the cycle after RST drops.
